// File: rtl/cache_bus_arbiter.sv
// Two-master arbiter sharing one sram-like memory port between I-cache and D-cache.
// One transaction in flight; the winning request is latched to keep the bus stable.
module cache_bus_arbiter #(
    parameter int FIXED_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_addr_hs;
    logic        w_done;
    logic        w_any_req;
    logic        w_arb;
    logic        w_win_data;

    // Address handshake only counts while the request is on the bus.
    assign w_addr_hs = (r_state == S_ADDR) && mem_addr_ok;

    // Completion: data_ok in DATA, or together with the address handshake.
    assign w_done = mem_data_ok && ((r_state == S_DATA) || w_addr_hs);

    assign w_any_req = inst_req | data_req;

    // Grant opportunities: bus idle, or the current transaction finishing.
    assign w_arb = w_any_req && ((r_state == S_IDLE) || w_done);

    // Data wins alone, or on a tie with fixed priority, or when inst went last.
    assign w_win_data = data_req
                      && (!inst_req || (FIXED_PRIO != 0) || !r_last_owner);

    // Transaction FSM with latched request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else if (w_arb) begin
            r_state      <= S_ADDR;
            r_owner      <= w_win_data;
            r_last_owner <= w_win_data;
            r_wr         <= w_win_data ? data_wr    : inst_wr;
            r_size       <= w_win_data ? data_size  : inst_size;
            r_addr       <= w_win_data ? data_addr  : inst_addr;
            r_wdata      <= w_win_data ? data_wdata : inst_wdata;
        end else if (w_done) begin
            r_state      <= S_IDLE;
        end else if (w_addr_hs) begin
            r_state      <= S_DATA;
        end
    end

    assign mem_req   = (r_state == S_ADDR);
    assign mem_wr    = r_wr;
    assign mem_size  = r_size;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign inst_addr_ok = w_addr_hs && !r_owner;
    assign data_addr_ok = w_addr_hs &&  r_owner;
    assign inst_data_ok = w_done    && !r_owner;
    assign data_data_ok = w_done    &&  r_owner;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_cache_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        sel;

    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok, mem_data_ok;

    logic [31:0] a_inst_rdata [2];
    logic        a_inst_addr_ok [2];
    logic        a_inst_data_ok [2];
    logic [31:0] a_data_rdata [2];
    logic        a_data_addr_ok [2];
    logic        a_data_data_ok [2];
    logic        a_mem_req [2];
    logic        a_mem_wr [2];
    logic [1:0]  a_mem_size [2];
    logic [31:0] a_mem_addr [2];
    logic [31:0] a_mem_wdata [2];

    // Instance 0 uses fixed priority, instance 1 round-robin.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_bus_arbiter #(.FIXED_PRIO(1 - g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .inst_req     (inst_req),
            .inst_wr      (inst_wr),
            .inst_size    (inst_size),
            .inst_addr    (inst_addr),
            .inst_wdata   (inst_wdata),
            .inst_rdata   (a_inst_rdata[g]),
            .inst_addr_ok (a_inst_addr_ok[g]),
            .inst_data_ok (a_inst_data_ok[g]),
            .data_req     (data_req),
            .data_wr      (data_wr),
            .data_size    (data_size),
            .data_addr    (data_addr),
            .data_wdata   (data_wdata),
            .data_rdata   (a_data_rdata[g]),
            .data_addr_ok (a_data_addr_ok[g]),
            .data_data_ok (a_data_data_ok[g]),
            .mem_req      (a_mem_req[g]),
            .mem_wr       (a_mem_wr[g]),
            .mem_size     (a_mem_size[g]),
            .mem_addr     (a_mem_addr[g]),
            .mem_wdata    (a_mem_wdata[g]),
            .mem_rdata    (mem_rdata),
            .mem_addr_ok  (mem_addr_ok),
            .mem_data_ok  (mem_data_ok)
        );
    end

    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, inst_rdata, data_rdata;
    logic        ia, id, da, dd;

    assign mem_req    = a_mem_req[sel];
    assign mem_wr     = a_mem_wr[sel];
    assign mem_size   = a_mem_size[sel];
    assign mem_addr   = a_mem_addr[sel];
    assign mem_wdata  = a_mem_wdata[sel];
    assign inst_rdata = a_inst_rdata[sel];
    assign data_rdata = a_data_rdata[sel];
    assign ia         = a_inst_addr_ok[sel];
    assign id         = a_inst_data_ok[sel];
    assign da         = a_data_addr_ok[sel];
    assign dd         = a_data_data_ok[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] ctl_out();
        return {mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
                ia, id, da, dd};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0;
        data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Grant-from-idle vector table.
    typedef struct {
        logic        s;
        logic        ir;
        logic        dr;
        logic        e_req;
        logic        e_wr;
        logic [31:0] e_addr;
    } vec_t;

    localparam logic [31:0] IA = 32'h1000_0100;
    localparam logic [31:0] DA = 32'h2000_0200;

    task automatic run_table();
        vec_t tv[7];
        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, IA};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, DA};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, DA};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, DA};
        tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IA};
        tv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, DA};
        for (int i = 0; i < 7; i++) begin
            sel = tv[i].s;
            do_reset();
            inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IA;
            data_wr = 1'b1; data_size = 2'd2; data_addr = DA;
            data_wdata = 32'hA5A5_0000 + 32'(i);
            inst_req = tv[i].ir;
            data_req = tv[i].dr;
            step();
            #1;
            chk($sformatf("vec%0d grant", i),
                160'({mem_req, mem_wr, mem_addr, ia, id, da, dd}),
                160'({tv[i].e_req, tv[i].e_wr, tv[i].e_addr, 4'b0}));
        end
    endtask

    // Reference model: one transaction record, its bus phase, last winner.
    localparam int P_NONE = 0;
    localparam int P_ISSUED = 1;
    localparam int P_ACC = 2;

    task automatic run_random(input logic s, input int n);
        logic        fixed;
        logic        iack, dack, hs, fin, win;
        logic        m_who, m_wr, m_last;
        logic [1:0]  m_size;
        logic [31:0] m_addr, m_wdata;
        int          m_phase;
        logic [135:0] exp;
        fixed = (s == 1'b0);
        sel = s;
        do_reset();
        m_who = 0; m_wr = 0; m_last = 0; m_size = 0;
        m_addr = 0; m_wdata = 0; m_phase = P_NONE;
        iack = 0; dack = 0;
        for (int c = 0; c < n; c++) begin
            if (iack) inst_req = 1'b0;
            if (dack) data_req = 1'b0;
            if (!inst_req && $urandom_range(3, 0) == 0) begin
                inst_req   = 1'b1;
                inst_wr    = 1'($urandom_range(1, 0));
                inst_size  = 2'($urandom_range(2, 0));
                inst_addr  = $urandom;
                inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(3, 0) == 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(1, 0));
                data_size  = 2'($urandom_range(2, 0));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            mem_addr_ok = 1'($urandom_range(1, 0));
            mem_data_ok = ($urandom_range(2, 0) == 0);
            mem_rdata   = $urandom;
            #1;
            hs  = (m_phase == P_ISSUED) && mem_addr_ok;
            fin = mem_data_ok && ((m_phase == P_ACC) || hs);
            exp = {m_phase == P_ISSUED, m_wr, m_size, m_addr, m_wdata,
                   hs && !m_who, fin && !m_who, hs && m_who, fin && m_who,
                   mem_rdata, mem_rdata};
            chk($sformatf("rand%0d cyc%0d", s, c),
                160'({ctl_out(), inst_rdata, data_rdata}), 160'(exp));
            iack = hs && !m_who;
            dack = hs &&  m_who;
            if ((inst_req || data_req) && (m_phase == P_NONE || fin)) begin
                if (inst_req && data_req) win = fixed ? 1'b1 : !m_last;
                else win = data_req;
                m_who   = win;
                m_last  = win;
                m_wr    = win ? data_wr    : inst_wr;
                m_size  = win ? data_size  : inst_size;
                m_addr  = win ? data_addr  : inst_addr;
                m_wdata = win ? data_wdata : inst_wdata;
                m_phase = P_ISSUED;
            end else if (fin) begin
                m_phase = P_NONE;
            end else if (hs) begin
                m_phase = P_ACC;
            end
            step();
        end
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Reset state on both variants.
        for (int k = 0; k < 2; k++) begin
            sel = 1'(k);
            do_reset();
            mem_rdata = 32'hCAFE_0001;
            #1;
            chk($sformatf("reset%0d", k),
                160'({ctl_out(), inst_rdata, data_rdata}),
                160'({72'b0, 32'hCAFE_0001, 32'hCAFE_0001}));
        end

        run_table();

        // Lone I-cache read.
        sel = 1'b0;
        do_reset();
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1FC0_0000;
        #1 chk("A pre-grant", 160'(mem_req), 160'(0));
        step();
        #1 chk("A grant", 160'({mem_req, mem_wr, mem_addr}),
               160'({1'b1, 1'b0, 32'h1FC0_0000}));
        mem_addr_ok = 1;
        #1 chk("A addr_ok", 160'({ia, da}), 160'(2'b10));
        step();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        mem_rdata = 32'h3C1D_BFC0;
        #1 chk("A data_ok", 160'({id, dd, mem_req, inst_rdata}),
               160'({3'b100, 32'h3C1D_BFC0}));
        step();
        mem_data_ok = 0;
        #1 chk("A idle", 160'({mem_req, ia, id, da, dd}), 160'(0));

        // Simultaneous requests, fixed priority.
        do_reset();
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1FC0_0004;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_0010;
        data_wdata = 32'hDEAD_BEEF;
        step();
        #1 chk("B data first",
               160'({mem_req, mem_wr, mem_addr, mem_wdata}),
               160'({2'b11, 32'h8000_0010, 32'hDEAD_BEEF}));
        mem_addr_ok = 1;
        #1 chk("B d addr_ok", 160'({ia, da}), 160'(2'b01));
        step();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1 chk("B d data_ok", 160'({id, dd}), 160'(2'b01));
        step();
        mem_data_ok = 0;
        #1 chk("B inst no gap", 160'({mem_req, mem_wr, mem_addr}),
               160'({2'b10, 32'h1FC0_0004}));
        mem_addr_ok = 1;
        #1 chk("B i addr_ok", 160'({ia, id, da, dd}), 160'(4'b1000));
        step();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1 chk("B i data_ok", 160'({ia, id, da, dd}), 160'(4'b0100));
        step();
        mem_data_ok = 0;
        #1 chk("B idle", 160'(mem_req), 160'(0));

        // Round-robin with both sides always requesting.
        sel = 1'b1;
        do_reset();
        inst_req = 1; inst_addr = 32'h1000_0000;
        data_req = 1; data_addr = 32'h2000_0000;
        step();
        for (int k = 0; k < 4; k++) begin
            mem_addr_ok = 1; mem_data_ok = 0;
            #1 chk($sformatf("C rr grant%0d", k),
                   160'({mem_req, mem_addr[31:28]}),
                   160'({1'b1, (k % 2 == 0) ? 4'h2 : 4'h1}));
            step();
            mem_addr_ok = 0; mem_data_ok = 1;
            if (k % 2 == 0) data_addr = data_addr + 32'd4;
            else inst_addr = inst_addr + 32'd4;
            step();
        end
        mem_data_ok = 0; inst_req = 0; data_req = 0;

        // Latched fields hold while the address phase stalls.
        sel = 1'b0;
        do_reset();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0020;
        step();
        data_addr = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("D hold%0d", k), 160'({mem_req, mem_addr}),
                   160'({1'b1, 32'h8000_0020}));
            step();
        end
        mem_addr_ok = 1;
        #1 chk("D addr_ok", 160'({da, ia}), 160'(2'b10));
        step();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1 chk("D data_ok", 160'({dd, id}), 160'(2'b10));
        step();
        mem_data_ok = 0;

        // Reset while waiting for data.
        do_reset();
        inst_req = 1; inst_wr = 1; inst_size = 2;
        inst_addr = 32'hA000_0040; inst_wdata = 32'h1122_3344;
        step();
        mem_addr_ok = 1;
        step();
        inst_req = 0; mem_addr_ok = 0;
        rst = 1; mem_data_ok = 1;
        #1 chk("E rst outputs", 160'(ctl_out()), 160'(0));
        step();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("E post-rst%0d", k), 160'(ctl_out()), 160'(0));
            step();
        end
        mem_data_ok = 0;

        // Stray handshakes in idle.
        do_reset();
        mem_addr_ok = 1; mem_data_ok = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("F stray%0d", k),
                   160'({mem_req, ia, id, da, dd}), 160'(0));
            step();
        end
        mem_addr_ok = 0; mem_data_ok = 0;
        inst_req = 1; inst_addr = 32'h0000_1234;
        step();
        #1 chk("F still idle", 160'({mem_req, mem_addr}),
               160'({1'b1, 32'h0000_1234}));

        run_random(1'b0, 1500);
        run_random(1'b1, 1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
